// File: rtl/gate_bist_pkg.sv
// rtl/gate_bist_pkg.sv - state encoding and truth-table constants for gate_bist
package gate_bist_pkg;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // Bit i is the expected output for input vector i, with stim[0] = a.
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_XOR2  = 4'b0110;
   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - exhaustive stimulus walker and truth-table checker for small gates
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int                      N_IN        = 2,
   parameter int                      SETTLE      = 2,
   parameter logic [(1<<N_IN)-1:0]    TRUTH_TABLE = TT_OR2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [N_IN-1:0]   stim,
   input  logic              y_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_count,
   output logic              fail_valid,
   output logic [N_IN-1:0]   fail_vec
);

   localparam int              NV       = 1 << N_IN;
   localparam int              CW       = $clog2(SETTLE + 1);
   localparam logic [N_IN:0]   LAST_IDX = (N_IN+1)'(NV - 1);
   localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(NV);
   localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);

   logic [1:0]        state_q, state_d;
   logic [N_IN:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N_IN-1:0]   stim_q, stim_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [N_IN:0]     err_q, err_d;
   logic              fvalid_q, fvalid_d;
   logic [N_IN-1:0]   fvec_q, fvec_d;
   logic              mismatch;

   assign mismatch = (y_in != TRUTH_TABLE[idx_q[N_IN-1:0]]);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      stim_d   = stim_q;
      pass_d   = pass_q;
      err_d    = err_q;
      fvalid_d = fvalid_q;
      fvec_d   = fvec_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            // A restart from DONE is indistinguishable from a launch from IDLE.
            if (start) begin
               state_d  = S_SETTLE;
               idx_d    = '0;
               cnt_d    = '0;
               stim_d   = '0;
               pass_d   = 1'b0;
               err_d    = '0;
               fvalid_d = 1'b0;
               fvec_d   = '0;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            if (mismatch) begin
               if (err_q != ERR_MAX) err_d = err_q + (N_IN+1)'(1);
               if (!fvalid_q) begin
                  fvalid_d = 1'b1;
                  fvec_d   = idx_q[N_IN-1:0];
               end
            end
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
               stim_d  = '0;
               pass_d  = (err_d == '0);
            end else begin
               idx_d   = idx_q + (N_IN+1)'(1);
               stim_d  = idx_d[N_IN-1:0];
               state_d = S_SETTLE;
            end
         end
      endcase
      busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         stim_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         fvalid_q <= 1'b0;
         fvec_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         stim_q   <= stim_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         fvalid_q <= fvalid_d;
         fvec_q   <= fvec_d;
      end
   end

   assign stim       = stim_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fvalid_q;
   assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - self-checking bench for gate_bist with swappable gates under test
module tb_gate_bist;
   import gate_bist_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start0, start1, start2;
   logic [1:0] stim0; logic y0, busy0, done0, pass0, fv0; logic [2:0] err0; logic [1:0] fvec0;
   logic [0:0] stim1; logic y1, busy1, done1, pass1, fv1; logic [1:0] err1; logic [0:0] fvec1;
   logic [2:0] stim2; logic y2, busy2, done2, pass2, fv2; logic [3:0] err2; logic [2:0] fvec2;

   int sel;
   logic [3:0] mask0;
   logic [7:0] mask2;
   logic [3:0] tt_or;

   // Gate under test for dut0: 0 or, 1 and, 2 stuck-0, 3 stuck-1, 4 xor, 5 nor, 6 nand, else faulty OR stub
   always_comb begin
      case (sel)
         0: y0 = stim0[0] | stim0[1];
         1: y0 = stim0[0] & stim0[1];
         2: y0 = 1'b0;
         3: y0 = 1'b1;
         4: y0 = stim0[0] ^ stim0[1];
         5: y0 = ~(stim0[0] | stim0[1]);
         6: y0 = ~(stim0[0] & stim0[1]);
         default: y0 = tt_or[stim0] ^ mask0[stim0];
      endcase
   end
   assign y1 = ~stim1[0];
   assign y2 = (^stim2) ^ mask2[stim2];

   gate_bist #(.N_IN(2), .SETTLE(2), .TRUTH_TABLE(TT_OR2)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .stim(stim0), .y_in(y0), .busy(busy0), .done(done0),
      .pass(pass0), .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0));
   gate_bist #(.N_IN(1), .SETTLE(1), .TRUTH_TABLE(2'b01)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .stim(stim1), .y_in(y1), .busy(busy1), .done(done1),
      .pass(pass1), .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1));
   gate_bist #(.N_IN(3), .SETTLE(3), .TRUTH_TABLE(8'h96)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .stim(stim2), .y_in(y2), .busy(busy2), .done(done2),
      .pass(pass2), .err_count(err2), .fail_valid(fv2), .fail_vec(fvec2));

   int n_chk = 0;
   int n_fail = 0;

   typedef struct { int sel; int err; int fv; int fvec; } vec_t;
   vec_t tbl[8];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic get(input int id, output int d, output int b, output int p, output int e,
                      output int v, output int f, output int s);
      case (id)
         0: begin d = done0; b = busy0; p = pass0; e = err0; v = fv0; f = fvec0; s = stim0; end
         1: begin d = done1; b = busy1; p = pass1; e = err1; v = fv1; f = fvec1; s = stim1; end
         default: begin d = done2; b = busy2; p = pass2; e = err2; v = fv2; f = fvec2; s = stim2; end
      endcase
   endtask

   task automatic set_start(input int id, input logic val);
      case (id)
         0: start0 = val;
         1: start1 = val;
         default: start2 = val;
      endcase
   endtask

   task automatic check_reset(input int id, input string nm);
      int d, b, p, e, v, f, s;
      get(id, d, b, p, e, v, f, s);
      chk({nm, " done"}, d, 0); chk({nm, " busy"}, b, 0); chk({nm, " pass"}, p, 0);
      chk({nm, " err"}, e, 0); chk({nm, " fvalid"}, v, 0); chk({nm, " fvec"}, f, 0);
      chk({nm, " stim"}, s, 0);
   endtask

   task automatic check_results(input int id, input string nm, input int e_err, input int e_fv, input int e_fvec);
      int d, b, p, e, v, f, s;
      get(id, d, b, p, e, v, f, s);
      chk({nm, " done"}, d, 1); chk({nm, " busy"}, b, 0); chk({nm, " pass"}, p, (e_err == 0) ? 1 : 0);
      chk({nm, " err"}, e, e_err); chk({nm, " fvalid"}, v, e_fv); chk({nm, " fvec"}, f, e_fvec);
      chk({nm, " stim"}, s, 0);
   endtask

   task automatic run(input int id, input int lat, input int e_err, input int e_fv, input int e_fvec, input string nm);
      int n, d, b, p, e, v, f, s;
      @(negedge clk); set_start(id, 1'b1);
      @(negedge clk); set_start(id, 1'b0);
      n = 0;
      get(id, d, b, p, e, v, f, s);
      while (d == 0 && n < 200) begin
         @(negedge clk); n++;
         get(id, d, b, p, e, v, f, s);
      end
      chk({nm, " latency"}, n, lat);
      check_results(id, nm, e_err, e_fv, e_fvec);
   endtask

   function automatic void model(input logic [7:0] m, input int nv, output int e, output int fv, output int f);
      e = 0; fv = 0; f = 0;
      for (int v = 0; v < nv; v++) begin
         if (m[v]) begin
            e++;
            if (fv == 0) begin fv = 1; f = v; end
         end
      end
   endfunction

   initial begin
      int n, e, fv, f;
      tt_or = TT_OR2;
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      sel = 0; mask0 = '0; mask2 = '0;
      tbl[0] = '{0, 0, 0, 0};  tbl[1] = '{1, 2, 1, 1};  tbl[2] = '{1, 2, 1, 1};
      tbl[3] = '{2, 3, 1, 1};  tbl[4] = '{3, 1, 1, 0};  tbl[5] = '{4, 1, 1, 3};
      tbl[6] = '{5, 4, 1, 0};  tbl[7] = '{6, 2, 1, 0};

      repeat (2) @(negedge clk);
      check_reset(0, "rst0"); check_reset(1, "rst1"); check_reset(2, "rst2");
      rst = 1'b0;

      // Walk with a good OR gate: each vector held SETTLE+1 cycles, done 12 edges after start
      sel = 0;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("t1 stim@%0d", i), stim0, i / 3);
         chk($sformatf("t1 busy@%0d", i), busy0, 1);
         chk($sformatf("t1 done@%0d", i), done0, 0);
         @(negedge clk);
      end
      check_results(0, "t1", 0, 0, 0);

      for (int i = 0; i < 8; i++) begin
         sel = tbl[i].sel;
         run(0, 12, tbl[i].err, tbl[i].fv, tbl[i].fvec, $sformatf("tbl%0d", i));
      end

      // start pulsed mid-run is ignored
      sel = 1;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      n = 0;
      while (!done0 && n < 200) begin
         @(negedge clk); n++;
         start0 = (n == 5);
      end
      start0 = 1'b0;
      chk("t4 latency", n, 12);
      check_results(0, "t4", 2, 1, 1);

      // Reset during SAMPLE of vector 2 with a pending mismatch
      sel = 2;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      repeat (8) @(negedge clk);
      chk("t5 stim before rst", stim0, 2);
      chk("t5 err before rst", err0, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset(0, "t5 after rst");
      sel = 0;
      run(0, 12, 0, 0, 0, "t5 fresh");

      // Inverter on a 1-input, SETTLE=1 instance, then start held high
      run(1, 4, 0, 0, 0, "t6");
      start1 = 1'b1;
      @(negedge clk);
      n = 0;
      while (!done1 && n < 50) begin @(negedge clk); n++; end
      chk("t6 held first done", done1, 1);
      @(negedge clk);
      chk("t6 held done drop", done1, 0);
      chk("t6 held busy again", busy1, 1);
      n = 0;
      while (!done1 && n < 50) begin @(negedge clk); n++; end
      chk("t6 held latency", n, 4);
      @(negedge clk);
      chk("t6 held one-cycle done", done1, 0);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 50) begin @(negedge clk); n++; end
      check_results(1, "t6 tail", 0, 0, 0);

      // Randomized fault masks against the reference model
      sel = 7;
      for (int r = 0; r < 12; r++) begin
         mask0 = 4'($urandom);
         model({4'b0, mask0}, 4, e, fv, f);
         run(0, 12, e, fv, f, $sformatf("rnd0_%0d m=%h", r, mask0));
      end
      for (int r = 0; r < 6; r++) begin
         mask2 = (r == 0) ? 8'hff : 8'($urandom);
         model(mask2, 8, e, fv, f);
         run(2, 32, e, fv, f, $sformatf("rnd2_%0d m=%h", r, mask2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Synthesizable stimulus generator and response checker for small combinational gates such as or_gate, and_gate and xor_gate.
- Sits directly upstream of the gate under test (drives its inputs) and directly downstream of it (samples its output).
- Walks all 2^N_IN input vectors, waits a settle time per vector, compares the output against a parameterized truth table, and reports pass/fail, error count and first failing vector.

Parameters:
- N_IN, 2: number of gate inputs; legal range 1..4.
- SETTLE, 2: cycles each vector is held before sampling; must be >= 1.
- TRUTH_TABLE, 4'b1110: expected output; bit i is the expected y for input vector i. Width 2^N_IN. Default is OR.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE or DONE to launch a run.
- stim  out  N_IN  vector driven to gate inputs; stim[0] = a, stim[1] = b.
- y_in  in  1  gate output under test.
- busy  out  1  high in SETTLE or SAMPLE.
- done  out  1  high while in DONE.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  N_IN+1  number of mismatching vectors; saturates at 2^N_IN.
- fail_valid  out  1  a mismatch has been captured this run.
- fail_vec  out  N_IN  first mismatching vector; 0 when fail_valid = 0.

Behaviour:
- Reset (rst = 1 at an edge) values:
  - state = IDLE; stim = 0.
  - busy, done, pass, fail_valid = 0.
  - err_count = 0; fail_vec = 0.
  - Internal idx = 0; settle counter cnt = 0.
- Reset mid-run aborts immediately to these values. No partial results are retained.
- States are IDLE, SETTLE, SAMPLE and DONE. All outputs are registered.
- IDLE:
  - stim = 0.
  - If start = 1, the next state is SETTLE and the following are set: idx = 0, cnt = 0, stim = 0, err_count = 0, fail_valid = 0, fail_vec = 0, pass = 0.
- SETTLE:
  - stim = idx, held constant.
  - cnt increments each cycle. When cnt == SETTLE-1, cnt clears and the next state is SAMPLE.
  - SETTLE therefore occupies exactly SETTLE cycles.
- SAMPLE (one cycle):
  - y_in is compared with TRUTH_TABLE[idx] at the closing edge.
  - On mismatch, err_count increments, saturating at 2^N_IN.
  - On the first mismatch of a run, fail_vec = idx and fail_vec latches; fail_valid goes to 1.
  - If idx == 2^N_IN-1, the next state is DONE. Otherwise idx increments and the next state is SETTLE.
- DONE:
  - done = 1; pass = (err_count == 0), registered on entry.
  - stim returns to 0.
  - Results hold until start = 1 (a restart identical to the IDLE launch) or rst.
- Latency:
  - With start sampled at edge k, done rises at edge k + 2^N_IN*(SETTLE+1).
  - For N_IN=2, SETTLE=2 this is k+12.
- start while busy is ignored; the run is not restarted.
- start held high continuously gives back-to-back runs, with DONE lasting exactly 1 cycle.
- y_in equal to X/Z counts as a mismatch in simulation. The check is !==-style in the bench model only; the RTL uses plain compare.
- Mismatch on the last vector still reaches DONE with the updated err_count visible in the same cycle done rises.
- idx width is N_IN+1 internally so the terminal compare does not wrap.

Decomposition:
- Package gate_bist_pkg holds:
  - State encoding: IDLE = 2'd0, SETTLE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3.
  - Truth-table constants: TT_OR2 = 4'b1110, TT_AND2 = 4'b1000, TT_XOR2 = 4'b0110, TT_NAND2 = 4'b0111, TT_NOR2 = 4'b0001.
- Single module; no sub-module is natural. The settle counter and scoreboard are too small to split.
- The bench instantiates gate_bist plus the gate under test. The DUT is swappable via a wrapper selecting or_gate, and_gate, or a faulty stub.

Test Plan:
1. Default params, or_gate connected; rst 2 cycles, then start pulse 1 cycle -> stim sequence 00,01,10,11, each held 3 cycles; done at start+12; pass = 1, err_count = 0, fail_valid = 0.
2. y_in tied to 0, TRUTH_TABLE = TT_OR2 -> err_count = 3, fail_valid = 1, fail_vec = 2'b01, pass = 0.
3. and_gate connected, TRUTH_TABLE = TT_OR2 -> err_count = 2 (vectors 01, 10), fail_vec = 01; a restart after done clears counters, and a second run reproduces identical results.
4. start pulsed again at cycle 5 of a run -> ignored; done still at original start+12; err_count unchanged.
5. rst asserted during SAMPLE of vector 10 with a pending mismatch -> next cycle all outputs at reset values, err_count = 0, busy = 0; a fresh start completes normally.
6. N_IN=1, SETTLE=1, TRUTH_TABLE = 2'b01 (inverter), y_in = !stim[0] -> done at start+4, pass = 1; start held high -> done high 1 cycle, then busy again.
